// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_COUNT = 2'd1,
      ST_PAUSE = 2'd2
   } sw_state_e;

   localparam int unsigned SEC0_MAX = 9;
   localparam int unsigned SEC1_MAX = 5;
   localparam int unsigned MIN0_MAX = 9;
   localparam int unsigned MIN1_MAX = 5;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// One BCD digit of the time chain: counts 0..MAX, wraps to 0 and raises
// carry in the same cycle so the next digit advances on the same edge.
module bcd_digit_cnt #(
   parameter int unsigned MAX = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] value,
   output logic       carry
);

   localparam logic [3:0] MAX_V = 4'(MAX);

   logic [3:0] value_q;

   // Digit register: clear wins over increment, increment wraps at MAX.
   // NOTE: sequential state uses non-blocking assignments with the async
   // reset in the sensitivity list so every register clears without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else if (clr) begin
         value_q <= '0;
      end else if (inc) begin
         value_q <= (value_q == MAX_V) ? 4'd0 : value_q + 4'd1;
      end
   end

   assign value = value_q;
   assign carry = inc && (value_q == MAX_V);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, RESET/COUNT/PAUSE FSM,
// one-second prescaler and an MM:SS BCD digit chain.
// Optional build macro STOPWATCH_SAT_EN: saturate at 59:59 and pause
// instead of wrapping to 00:00.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pb_start,
   input  logic       pb_lap,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic       rst_state,
   output logic       lap
);

   localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   sw_state_e        state_q;
   logic             rst_state_q;
   logic             lap_q;
   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;

   logic pb_start_q, pb_start_prev_q;
   logic pb_lap_q, pb_lap_prev_q;
   logic start_pulse, lap_pulse;

   logic tick, sat_hit, inc_sec, clr_digits;
   logic carry_sec0, carry_sec1, carry_min0, carry_min1_unused;

   // Button history: current sample and previous sample of each level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pb_start_q      <= 1'b0;
         pb_start_prev_q <= 1'b0;
         pb_lap_q        <= 1'b0;
         pb_lap_prev_q   <= 1'b0;
      end else begin
         pb_start_q      <= pb_start;
         pb_start_prev_q <= pb_start_q;
         pb_lap_q        <= pb_lap;
         pb_lap_prev_q   <= pb_lap_q;
      end
   end

   assign start_pulse = pb_start_q && !pb_start_prev_q;
   assign lap_pulse   = pb_lap_q && !pb_lap_prev_q;

   assign tick  = (state_q == ST_COUNT) && (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

`ifdef STOPWATCH_SAT_EN
   assign sat_hit = tick
                    && (sec0 == 4'(SEC0_MAX)) && (sec1 == 4'(SEC1_MAX))
                    && (min0 == 4'(MIN0_MAX)) && (min1 == 4'(MIN1_MAX));
`else
   assign sat_hit = 1'b0;
`endif

   // A start pulse coinciding with a tick still advances time.
   assign inc_sec    = tick && !sat_hit;
   assign clr_digits = (state_q == ST_RESET)
                       || ((state_q == ST_PAUSE) && lap_pulse && !start_pulse);

   // Control FSM with registered rst_state, lap flag and prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RESET;
         rst_state_q <= 1'b1;
         lap_q       <= 1'b0;
         pre_q       <= '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               pre_q <= '0;
               lap_q <= 1'b0;
               if (start_pulse) begin
                  state_q     <= ST_COUNT;
                  rst_state_q <= 1'b0;
               end
            end
            ST_COUNT: begin
               pre_q <= pre_d;
               if (start_pulse || sat_hit) begin
                  state_q <= ST_PAUSE;
               end else if (lap_pulse) begin
                  lap_q <= !lap_q;
               end
            end
            ST_PAUSE: begin
               if (start_pulse) begin
                  state_q <= ST_COUNT;
               end else if (lap_pulse) begin
                  state_q     <= ST_RESET;
                  rst_state_q <= 1'b1;
                  lap_q       <= 1'b0;
                  pre_q       <= '0;
               end
            end
            default: begin
               state_q     <= ST_RESET;
               rst_state_q <= 1'b1;
               lap_q       <= 1'b0;
               pre_q       <= '0;
            end
         endcase
      end
   end

   bcd_digit_cnt #(.MAX(SEC0_MAX)) u_sec0 (
      .clk(clk), .rst_n(rst_n), .inc(inc_sec), .clr(clr_digits),
      .value(sec0), .carry(carry_sec0)
   );
   bcd_digit_cnt #(.MAX(SEC1_MAX)) u_sec1 (
      .clk(clk), .rst_n(rst_n), .inc(carry_sec0), .clr(clr_digits),
      .value(sec1), .carry(carry_sec1)
   );
   bcd_digit_cnt #(.MAX(MIN0_MAX)) u_min0 (
      .clk(clk), .rst_n(rst_n), .inc(carry_sec1), .clr(clr_digits),
      .value(min0), .carry(carry_min0)
   );
   bcd_digit_cnt #(.MAX(MIN1_MAX)) u_min1 (
      .clk(clk), .rst_n(rst_n), .inc(carry_min0), .clr(clr_digits),
      .value(min1), .carry(carry_min1_unused)
   );

   assign rst_state = rst_state_q;
   assign lap       = lap_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000_000, clk cycles per counted second (>=2).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port pb_start  input  1  debounced start/stop button level.
REQ-005 SHALL have port pb_lap  input  1  debounced lap/reset button level.
REQ-006 SHALL have ports sec0, sec1, min0, min1  output  4 each  BCD time digits: sec0 0-9, sec1 0-5, min0 0-9, min1 0-5.
REQ-007 SHALL have port rst_state  output  1  high while in RESET state.
REQ-008 SHALL have port lap  output  1  lap-freeze request to downstream display mux.

Function
REQ-009 SHALL register both button levels and derive one-cycle press pulses (level 1 now, 0 previous sample); holding a button SHALL yield exactly one pulse.
REQ-010 SHALL implement FSM states RESET, COUNT, PAUSE.
REQ-011 RESET: start pulse -> COUNT; lap pulse ignored; digits, prescaler, lap held at 0.
REQ-012 COUNT: start pulse -> PAUSE; lap pulse toggles lap, state unchanged.
REQ-013 PAUSE: start pulse -> COUNT; lap pulse -> RESET, clearing digits, prescaler, lap on that edge.
REQ-014 Start and lap pulses in same cycle: start SHALL take effect, lap SHALL be ignored.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 only in COUNT, hold value in PAUSE (fractional second kept), clear in RESET; tick asserted in cycle prescaler = TICK_DIV-1, prescaler wraps to 0.
REQ-016 On tick, time SHALL increment by one second: sec0 9->0 carries to sec1, sec1 5->0 carries to min0, min0 9->0 carries to min1.
REQ-017 At 59:59 on tick without macro: wrap to 00:00, remain COUNT.
REQ-018 Tick and start pulse in same cycle: increment SHALL still occur, then state -> PAUSE.
REQ-019 All outputs SHALL be registered; a press or tick is visible on outputs one clk after the sampling edge.
REQ-020 rst_state SHALL equal 1 exactly when state is RESET.
REQ-021 lap SHALL persist across COUNT<->PAUSE transitions.

Reset
REQ-022 On rst_n low, asynchronously: state RESET, all digits 0, lap 0, rst_state 1, prescaler 0, button history 0.
REQ-023 Reset mid-count SHALL discard time; a button held through reset release SHALL produce a pulse on first sampled edge.

Configuration
REQ-024 Macro STOPWATCH_SAT_EN defined: at 59:59 a tick SHALL hold 59:59 and force state PAUSE; lap unchanged.
REQ-025 Macro undefined: wrap per REQ-017, no saturation logic compiled.

Structure
REQ-026 Package stopwatch_pkg SHALL hold FSM state typedef and constants SEC0_MAX=9, SEC1_MAX=5, MIN0_MAX=9, MIN1_MAX=5.
REQ-027 Sub-module bcd_digit_cnt (parameter MAX; inc, clr in; 4-bit value, carry out) SHALL be instanced four times in a carry chain.

Verification (TICK_DIV=4)
REQ-028 Reset, single start press, 40 clk -> digits 00:10, rst_state 0, lap 0.
REQ-029 Counting, start press at 00:03 + 2 prescale cycles, later start again -> time frozen in PAUSE, next second arrives exactly 2 clk after resume.
REQ-030 In COUNT, lap press twice -> lap 1 then 0, digits keep incrementing throughout.
REQ-031 PAUSE at 00:07 with lap=1, lap press -> next cycle 00:00, lap 0, rst_state 1; lap press in RESET -> no change.
REQ-032 Preload 59:58, 8 clk -> 00:00 in COUNT; with STOPWATCH_SAT_EN -> 59:59 and PAUSE.
REQ-033 Start and lap pressed same cycle in COUNT -> PAUSE, lap unchanged; rst_n pulse mid-count -> all outputs reset values immediately.
